// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output reorder stage.
package fft_pkg;

    localparam int unsigned SAMPLE_W     = 16;
    localparam int unsigned BITREV_MAX_W = 16;
    localparam int unsigned BITREV_IDX_W = $clog2(BITREV_MAX_W);

    typedef struct packed {
        logic [SAMPLE_W-1:0] re;
        logic [SAMPLE_W-1:0] im;
    } cplx_t;

    function automatic int unsigned log2n(input int unsigned n);
        return $clog2(n);
    endfunction

    // Reverse the low nbits of idx; upper bits of the result are zero.
    function automatic logic [BITREV_MAX_W-1:0] bitrev(
        input logic [BITREV_MAX_W-1:0] idx,
        input int unsigned             nbits
    );
        logic [BITREV_MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < BITREV_MAX_W; i++) begin
            if (i < nbits) begin
                r[BITREV_IDX_W'(i)] = idx[BITREV_IDX_W'(nbits - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_reorder_ram.sv
// Two-bank simple dual-port RAM, address {bank, idx}, registered read port.
module fft_pingpong_ram #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    // A read colliding with a write to the same address returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT frames into natural order via ping-pong banks.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N_POINTS   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_val,
    output logic                  in_rdy,
    input  logic [DATA_WIDTH-1:0] in_re,
    input  logic [DATA_WIDTH-1:0] in_im,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_re,
    output logic [DATA_WIDTH-1:0] out_im,
    output logic                  out_last
);

    localparam int unsigned LOG2N  = log2n(N_POINTS);
    localparam int unsigned ADDR_W = LOG2N + 1;
    localparam int unsigned WORD_W = 2 * DATA_WIDTH;
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_POINTS - 1);

    logic [1:0]        bank_full;
    logic [1:0]        bank_full_nxt;
    logic              wr_bank;
    logic              rd_bank;
    logic              rd_bank_nxt;
    logic [LOG2N-1:0]  wr_cnt;
    logic [LOG2N-1:0]  rd_cnt;
    logic [LOG2N-1:0]  rd_cnt_nxt;
    logic [LOG2N-1:0]  wr_idx_c;
    logic              wr_en_c;
    logic              wr_wrap_c;
    logic              load_c;
    logic              rd_wrap_c;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;

    assign in_rdy    = ~bank_full[wr_bank];
    assign wr_en_c   = in_val & in_rdy;
    assign wr_wrap_c = wr_en_c & (wr_cnt == LAST_IDX);
    assign load_c    = bank_full[rd_bank] & (~out_val | out_rdy);
    assign rd_wrap_c = load_c & (rd_cnt == LAST_IDX);
    assign wr_idx_c  = LOG2N'(bitrev(BITREV_MAX_W'(wr_cnt), LOG2N));
    assign wr_word   = {in_re, in_im};

    // Next read pointer; it also addresses the RAM so its registered read
    // already holds the word the following load will consume.
    always_comb begin
        bank_full_nxt = bank_full;
        rd_bank_nxt   = rd_bank;
        rd_cnt_nxt    = rd_cnt;
        if (wr_wrap_c) begin
            bank_full_nxt[wr_bank] = 1'b1;
        end
        if (rd_wrap_c) begin
            bank_full_nxt[rd_bank] = 1'b0;
        end
        if (load_c) begin
            if (rd_wrap_c) begin
                rd_cnt_nxt  = '0;
                rd_bank_nxt = ~rd_bank;
            end else begin
                rd_cnt_nxt = rd_cnt + LOG2N'(1);
            end
        end
    end

    fft_pingpong_ram #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en_c),
        .wr_addr ({wr_bank, wr_idx_c}),
        .wr_data (wr_word),
        .rd_addr ({rd_bank_nxt, rd_cnt_nxt}),
        .rd_data (rd_word)
    );

    // Write side: scatter each sample to its bit-reversed slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_bank <= 1'b0;
            wr_cnt  <= '0;
        end else if (wr_en_c) begin
            if (wr_wrap_c) begin
                wr_cnt  <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_cnt <= wr_cnt + LOG2N'(1);
            end
        end
    end

    // Bank flags and read pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bank_full <= '0;
            rd_bank   <= 1'b0;
            rd_cnt    <= '0;
        end else begin
            bank_full <= bank_full_nxt;
            rd_bank   <= rd_bank_nxt;
            rd_cnt    <= rd_cnt_nxt;
        end
    end

    // Output register: load on free slot, hold while stalled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_val  <= 1'b0;
            out_last <= 1'b0;
            out_re   <= '0;
            out_im   <= '0;
        end else if (load_c) begin
            out_val  <= 1'b1;
            out_last <= rd_wrap_c;
            out_re   <= rd_word[WORD_W-1 -: DATA_WIDTH];
            out_im   <= rd_word[DATA_WIDTH-1:0];
        end else if (out_val && out_rdy) begin
            out_val <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder (N=16, 16-bit components).
module tb_fft_bitrev_reorder;
    import fft_pkg::*;

    localparam int NP       = 16;
    localparam int RDY_ON   = 0;
    localparam int RDY_OFF  = 1;
    localparam int RDY_RAND = 2;

    typedef struct packed {
        cplx_t s;
        logic  last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_val;
    logic        in_rdy;
    logic [15:0] in_re;
    logic [15:0] in_im;
    logic        out_val;
    logic        out_rdy;
    logic [15:0] out_re;
    logic [15:0] out_im;
    logic        out_last;

    exp_t  sb_q[$];
    int    xfer_log[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    stalls = 0;
    int    fcnt = 0;
    int    last_acc_edge = 0;
    int    rdy_mode = RDY_ON;
    logic  use_table = 1'b0;
    cplx_t frame_buf [NP];
    logic [15:0] tbl [16] = '{16'd0, 16'd8, 16'd4, 16'd12, 16'd2, 16'd10, 16'd6, 16'd14,
                              16'd1, 16'd9, 16'd5, 16'd13, 16'd3, 16'd11, 16'd7, 16'd15};

    fft_bitrev_reorder #(
        .DATA_WIDTH (16),
        .N_POINTS   (NP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_re    (in_re),
        .in_im    (in_im),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_re   (out_re),
        .out_im   (out_im),
        .out_last (out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] rev4(input logic [3:0] x);
        return {x[0], x[1], x[2], x[3]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void push_frame();
        exp_t e;
        for (int j = 0; j < NP; j++) begin
            if (use_table) begin
                e.s.re = tbl[4'(j)];
                e.s.im = 16'h0100 + tbl[4'(j)];
            end else begin
                e.s = frame_buf[rev4(4'(j))];
            end
            e.last = (j == NP - 1);
            sb_q.push_back(e);
        end
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_sample(input logic [15:0] re, input logic [15:0] im);
        int t;
        t = 0;
        in_val = 1'b1;
        in_re  = re;
        in_im  = im;
        while (!in_rdy && t < 2000) begin
            tick(1);
            t++;
            stalls++;
        end
        if (!in_rdy) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: in_rdy stuck at 0, required 1 within 2000 cycles");
            in_val = 1'b0;
            return;
        end
        last_acc_edge = cyc + 1;
        frame_buf[4'(fcnt)] = '{re: re, im: im};
        fcnt++;
        if (fcnt == NP) begin
            push_frame();
            fcnt = 0;
        end
        tick(1);
        in_val = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 5000) begin
            tick(1);
            t++;
        end
        chk("drain_empty", 32'(sb_q.size()), 0);
        tick(4);
    endtask

    task automatic do_reset(input int n);
        rst    = 1'b0;
        in_val = 1'b0;
        fcnt   = 0;
        tick(n);
        rst = 1'b1;
        sb_q.delete();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_out_val"},  32'(out_val),  0);
        chk({tag, "_out_last"}, 32'(out_last), 0);
        chk({tag, "_out_re"},   32'(out_re),   0);
        chk({tag, "_out_im"},   32'(out_im),   0);
        chk({tag, "_in_rdy"},   32'(in_rdy),   1);
    endtask

    // Downstream ready generator.
    initial begin
        out_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                RDY_ON:  out_rdy = 1'b1;
                RDY_OFF: out_rdy = 1'b0;
                default: out_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops on each transfer and checks stall stability.
    initial begin
        exp_t        e;
        logic        hold_v;
        logic [15:0] h_re;
        logic [15:0] h_im;
        logic        h_last;
        hold_v = 1'b0;
        h_re   = '0;
        h_im   = '0;
        h_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    chk("hold_val",  32'(out_val),  1);
                    chk("hold_re",   32'(out_re),   32'(h_re));
                    chk("hold_im",   32'(out_im),   32'(h_im));
                    chk("hold_last", 32'(out_last), 32'(h_last));
                end
                if (out_val && out_rdy) begin
                    xfer_log.push_back(cyc);
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_out: got re=0x%0h im=0x%0h, expected no output", out_re, out_im);
                    end else begin
                        e = sb_q.pop_front();
                        chk("out_re",   32'(out_re),   32'(e.s.re));
                        chk("out_im",   32'(out_im),   32'(e.s.im));
                        chk("out_last", 32'(out_last), 32'(e.last));
                    end
                end
                hold_v = out_val && !out_rdy;
                h_re   = out_re;
                h_im   = out_im;
                h_last = out_last;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit, required self-termination");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int cnt;
        rst    = 1'b0;
        in_val = 1'b0;
        in_re  = '0;
        in_im  = '0;
        tick(3);
        rst = 1'b1;
        chk_reset("por");

        // Single frame against the hand-computed order and latency.
        xfer_log.delete();
        use_table = 1'b1;
        for (int k = 0; k < NP; k++) send_sample(16'(k), 16'(16'h0100 + k));
        use_table = 1'b0;
        drain();
        chk("t1_count", 32'(xfer_log.size()), 16);
        if (xfer_log.size() > 0) chk("t1_latency", 32'(xfer_log[0]), 32'(last_acc_edge + 1));

        // Four back-to-back frames: no input stall, no output bubble.
        xfer_log.delete();
        stalls = 0;
        for (int f = 0; f < 4; f++)
            for (int k = 0; k < NP; k++)
                send_sample(16'(16 * f + k), 16'(16'hFFFF - (16 * f + k)));
        chk("t2_stalls", 32'(stalls), 0);
        drain();
        chk("t2_count", 32'(xfer_log.size()), 64);
        if (xfer_log.size() == 64) chk("t2_span", 32'(xfer_log[63] - xfer_log[0]), 63);

        // Backpressure with both banks full.
        rdy_mode = RDY_OFF;
        tick(1);
        for (int k = 0; k < 2 * NP; k++) send_sample(16'(k), 16'(16'h0200 + k));
        chk("t3_in_rdy_low", 32'(in_rdy), 0);
        chk("t3_out_val", 32'(out_val), 1);
        chk("t3_first_re", 32'(out_re), 0);
        chk("t3_first_im", 32'(out_im), 32'h0200);
        tick(5);
        chk("t3_still_full", 32'(in_rdy), 0);
        rdy_mode = RDY_ON;
        t = 0;
        while (!in_rdy && t < 40) begin
            tick(1);
            t++;
        end
        chk("t3_in_rdy_rise", 32'(t), 15);
        drain();

        // Random input gaps and random downstream ready.
        rdy_mode = RDY_RAND;
        for (int f = 0; f < 20; f++)
            for (int k = 0; k < NP; k++) begin
                tick(int'($urandom_range(0, 2)));
                send_sample(16'(16 * f + k) ^ 16'h5A5A, 16'($urandom));
            end
        drain();
        rdy_mode = RDY_ON;
        tick(2);

        // Reset in the middle of an input frame.
        for (int k = 0; k < 7; k++) send_sample(16'(16'h0700 + k), 16'(16'h0770 + k));
        do_reset(1);
        chk_reset("t5");
        use_table = 1'b1;
        for (int k = 0; k < NP; k++) send_sample(16'(k), 16'(16'h0100 + k));
        use_table = 1'b0;
        drain();

        // Reset in the middle of an output drain.
        xfer_log.delete();
        for (int k = 0; k < NP; k++) send_sample(16'(16'h0A00 + k), 16'(16'h0B00 + k));
        t = 0;
        while (xfer_log.size() < 5 && t < 200) begin
            tick(1);
            t++;
        end
        chk("t6_mid_drain", 32'(out_val), 1);
        do_reset(1);
        chk_reset("t6");
        cnt = 0;
        repeat (40) begin
            tick(1);
            if (out_val) cnt++;
        end
        chk("t6_no_stale", 32'(cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
